// File: rtl/sorted_merge_reader32_pkg.sv
// Shared types and helpers for the sorted merge reader.
// Holds the default word width, a constant-safe clog2 and the FSM state encoding.
// No logic lives here; it is only imported.
package sorted_merge_reader32_pkg;

    localparam int W_DEFAULT = 32;

    // Ceiling log2, never less than 1 so a degenerate size still yields a usable width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/sorted_merge_reader32_if.sv
// Frame-in / word-out bundle for the sorted merge reader.
// Input side carries two packed sorted arrays plus direction; output side is one word per beat.
// Both sides use valid/ready; the slave modport is the reader's view.
interface sorted_merge_reader32_if
    import sorted_merge_reader32_pkg::*;
#(
    parameter int K = 16,
    parameter int W = W_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    logic [W*K-1:0]   in_array_a;
    logic [W*K-1:0]   in_array_b;
    logic             dir;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_src;
    logic             out_last;

    modport master (
        output in_valid, in_array_a, in_array_b, dir, out_ready,
        input  in_ready, out_valid, out_data, out_src, out_last
    );

    modport slave (
        input  in_valid, in_array_a, in_array_b, dir, out_ready,
        output in_ready, out_valid, out_data, out_src, out_last
    );

endinterface

// File: rtl/sorted_merge_reader32_compare_select32.sv
// Head selector: decides whether the next merged word comes from B.
// Purely combinational, zero latency.
// No handshake; exhausted flags take priority, ties go to A so the merge is stable.
module compare_select32
    import sorted_merge_reader32_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] head_a,
    input  logic [W-1:0] head_b,
    input  logic         a_done,
    input  logic         b_done,
    input  logic         dir,
    output logic         select_b
);

    // Exhaustion first, then unsigned compare in the frame's direction.
    always_comb begin
        select_b = 1'b0;
        if (a_done) begin
            select_b = 1'b1;
        end else if (b_done) begin
            select_b = 1'b0;
        end else if (dir) begin
            select_b = (head_a > head_b);
        end else begin
            select_b = (head_a < head_b);
        end
    end

endmodule

// File: rtl/sorted_merge_reader32.sv
// Merges two pre-sorted K-word frames into one sorted 2K-word stream, one word per beat.
// Latency 1: first word valid the cycle after frame acceptance; a frame occupies >= 2K+1 cycles.
// Output stalls hold data/src/last stable; no new frame is taken until the last word is accepted.
module sorted_merge_reader32
    import sorted_merge_reader32_pkg::*;
#(
    parameter int K = 16,
    parameter int W = W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    sorted_merge_reader32_if.slave bus
);

    localparam int IW = clog2(K + 1);
    localparam int CW = clog2(2 * K);
    localparam logic [IW-1:0] IDX_K    = IW'(K);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * K - 1);

    state_t               state;
    state_t               state_nxt;
    logic [K-1:0][W-1:0]  a_q;
    logic [K-1:0][W-1:0]  b_q;
    logic                 dir_q;
    logic [IW-1:0]        idx_a;
    logic [IW-1:0]        idx_b;
    logic [CW-1:0]        cnt;

    logic                 a_done;
    logic                 b_done;
    logic [W-1:0]         head_a;
    logic [W-1:0]         head_b;
    logic                 select_b;
    logic                 is_last;
    logic                 accept;
    logic                 hs;
    logic                 in_ready_c;
    logic                 out_valid_c;

    assign a_done  = (idx_a == IDX_K);
    assign b_done  = (idx_b == IDX_K);
    assign is_last = (cnt == CNT_LAST);

    // Head word lookup; an exhausted side reads as zero and is never selected.
    always_comb begin
        head_a = '0;
        head_b = '0;
        for (int i = 0; i < K; i++) begin
            if (idx_a == IW'(i)) begin
                head_a = a_q[i];
            end
            if (idx_b == IW'(i)) begin
                head_b = b_q[i];
            end
        end
    end

    compare_select32 #(
        .W (W)
    ) u_select (
        .head_a   (head_a),
        .head_b   (head_b),
        .a_done   (a_done),
        .b_done   (b_done),
        .dir      (dir_q),
        .select_b (select_b)
    );

    // Next-state and handshake decode; in_ready is forced low while reset is asserted.
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        accept      = 1'b0;
        hs          = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = ~rst;
                accept     = bus.in_valid & ~rst;
                if (accept) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid_c = 1'b1;
                hs          = bus.out_ready;
                if (hs && is_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame capture and merge pointers; only the selected side advances per beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            dir_q <= 1'b0;
            idx_a <= '0;
            idx_b <= '0;
            cnt   <= '0;
        end else if (accept) begin
            a_q   <= bus.in_array_a;
            b_q   <= bus.in_array_b;
            dir_q <= bus.dir;
            idx_a <= '0;
            idx_b <= '0;
            cnt   <= '0;
        end else if (hs) begin
            if (select_b) begin
                idx_b <= idx_b + 1'b1;
            end else begin
                idx_a <= idx_a + 1'b1;
            end
            cnt <= is_last ? '0 : cnt + 1'b1;
        end
    end

    // Outputs derive from registered state only; idle shows zeros.
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = (state == EMIT) ? (select_b ? head_b : head_a) : '0;
    assign bus.out_src   = (state == EMIT) & select_b;
    assign bus.out_last  = (state == EMIT) & is_last;

endmodule

// File: tb/tb_sorted_merge_reader32.sv
// Bench for sorted_merge_reader32 with K=4, W=32.
// A queue-based merge model predicts every output beat; directed frames pin it with literals.
module tb_sorted_merge_reader32;

    localparam int K = 4;
    localparam int W = 32;

    typedef logic [K-1:0][W-1:0] arr_t;
    typedef logic [W-1:0] seq_t [2*K];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sorted_merge_reader32_if #(.K(K), .W(W)) bus ();

    sorted_merge_reader32 #(.K(K), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_data [$];
    logic         exp_src  [$];
    logic [W-1:0] cap_data [$];
    logic         cap_src  [$];
    int           hs_count = 0;
    int           accepts  = 0;
    logic         ready_mode = 1'b0;
    int           rdy_phase  = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic arr_t mk(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                input logic [W-1:0] w2, input logic [W-1:0] w3);
        arr_t r;
        r[0] = w0;
        r[1] = w1;
        r[2] = w2;
        r[3] = w3;
        return r;
    endfunction

    // Reference merge: repeatedly take the better front of two queues, ties to A.
    function automatic void model_load(input arr_t a, input arr_t b, input logic d);
        logic [W-1:0] qa [$];
        logic [W-1:0] qb [$];
        logic take_a;
        for (int i = 0; i < K; i++) begin
            qa.push_back(a[i]);
            qb.push_back(b[i]);
        end
        while (qa.size() + qb.size() > 0) begin
            if (qa.size() == 0)      take_a = 1'b0;
            else if (qb.size() == 0) take_a = 1'b1;
            else if (d)              take_a = (qa[0] <= qb[0]);
            else                     take_a = (qa[0] >= qb[0]);
            if (take_a) begin
                exp_data.push_back(qa.pop_front());
                exp_src.push_back(1'b0);
            end else begin
                exp_data.push_back(qb.pop_front());
                exp_src.push_back(1'b1);
            end
        end
    endfunction

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", 32'(bus.in_ready), 32'(!rst && exp_data.size() == 0));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_data.size() != 0));
            if (bus.out_valid && exp_data.size() != 0) begin
                chk("out_data", bus.out_data, exp_data[0]);
                chk("out_src", 32'(bus.out_src), 32'(exp_src[0]));
                chk("out_last", 32'(bus.out_last), 32'(exp_data.size() == 1));
                if (prev_stall) begin
                    chk("stall_hold", bus.out_data, prev_data);
                end
            end else if (!bus.out_valid) begin
                chk("idle_last", 32'(bus.out_last), 32'(0));
                chk("idle_data", bus.out_data, 32'(0));
            end
            if (rst) begin
                exp_data.delete();
                exp_src.delete();
                prev_stall = 1'b0;
            end else begin
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                if (bus.out_valid && bus.out_ready && exp_data.size() != 0) begin
                    cap_data.push_back(exp_data.pop_front());
                    cap_src.push_back(exp_src.pop_front());
                    hs_count++;
                end
                if (bus.in_valid && exp_data.size() == 0 && !bus.out_valid) begin
                    model_load(bus.in_array_a, bus.in_array_b, bus.dir);
                    accepts++;
                end
            end
        end
    end

    // Downstream ready: always-on, or the repeating 1,0,0 stall pattern.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!ready_mode) begin
                bus.out_ready = 1'b1;
            end else begin
                bus.out_ready = (rdy_phase % 3 == 0);
                rdy_phase++;
            end
        end
    end

    task automatic send(input arr_t a, input arr_t b, input logic d);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        bus.in_array_a = a;
        bus.in_array_b = b;
        bus.dir        = d;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            errors++;
            $display("FAIL send_timeout: in_ready never rose");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (exp_data.size() == 0 && !bus.out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: frame did not complete");
        end
    endtask

    task automatic check_seq(input string name, input seq_t d, input logic [2*K-1:0] s);
        chk({name, "_count"}, 32'(cap_data.size()), 32'(2 * K));
        if (cap_data.size() == 2 * K) begin
            for (int i = 0; i < 2 * K; i++) begin
                chk({name, "_data"}, cap_data[i], d[i]);
                chk({name, "_src"}, 32'(cap_src[i]), 32'(s[i]));
            end
        end
        cap_data.delete();
        cap_src.delete();
    endtask

    seq_t lit;
    arr_t a1, b1;
    int   acc0;
    bit   hit;

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_array_a = '0;
        bus.in_array_b = '0;
        bus.dir        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_data", bus.out_data, 32'(0));
        chk("rst_out_src", 32'(bus.out_src), 32'(0));
        chk("rst_out_last", 32'(bus.out_last), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'(1));

        a1 = mk(1, 3, 5, 7);
        b1 = mk(2, 4, 6, 8);

        // Interleaved ascending merge.
        send(a1, b1, 1'b1);
        drain();
        lit = '{1, 2, 3, 4, 5, 6, 7, 8};
        check_seq("asc", lit, 8'b10101010);

        // All ties: A drains before B.
        send(mk(5, 5, 5, 5), mk(5, 5, 5, 5), 1'b1);
        drain();
        lit = '{5, 5, 5, 5, 5, 5, 5, 5};
        check_seq("ties", lit, 8'b11110000);

        // Descending with duplicates in B.
        send(mk(9, 7, 3, 1), mk(8, 8, 2, 0), 1'b0);
        drain();
        lit = '{9, 8, 8, 7, 3, 2, 1, 0};
        check_seq("desc", lit, 8'b10100110);

        // Unsigned compare: all-ones words sort last; A exhausts first.
        send(mk(0, 1, 2, 3), mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1);
        drain();
        lit = '{0, 1, 2, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        check_seq("unsigned", lit, 8'b11110000);

        // Output backpressure with ready pattern 1,0,0.
        ready_mode = 1'b1;
        send(a1, b1, 1'b1);
        drain();
        ready_mode = 1'b0;
        lit = '{1, 2, 3, 4, 5, 6, 7, 8};
        check_seq("bp", lit, 8'b10101010);

        // in_valid held high: exactly two frames, second only after the first ends.
        acc0 = accepts;
        @(posedge clk);
        #1;
        bus.in_array_a = a1;
        bus.in_array_b = b1;
        bus.dir        = 1'b1;
        bus.in_valid   = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (accepts == acc0 + 2) begin
                hit = 1'b1;
                break;
            end
        end
        #1;
        bus.in_valid = 1'b0;
        if (!hit) begin
            errors++;
            $display("FAIL hold_valid_timeout: second frame never accepted");
        end
        drain();
        chk("hold_accepts", 32'(accepts - acc0), 32'(2));
        chk("hold_words", 32'(cap_data.size()), 32'(4 * K));
        cap_data.delete();
        cap_src.delete();

        // Reset after three words, then a fresh frame from index 0.
        hs_count = 0;
        send(a1, b1, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (hs_count == 3) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            errors++;
            $display("FAIL reset_wait_timeout: three words not seen");
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 32'(bus.out_valid), 32'(0));
        chk("abort_in_ready", 32'(bus.in_ready), 32'(1));
        chk("abort_partial", 32'(cap_data.size()), 32'(3));
        cap_data.delete();
        cap_src.delete();
        send(mk(10, 20, 30, 40), mk(15, 25, 35, 45), 1'b1);
        drain();
        lit = '{10, 15, 20, 25, 30, 35, 40, 45};
        check_seq("after_rst", lit, 8'b10101010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
